// File: rtl/m10k_stream_reader_pkg.sv
// Shared types and sizes for the M10K stream reader.
package m10k_stream_reader_pkg;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BUF_D  = 4;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] word_t;
  // Word counts run 0..2^ADDR_W inclusive, hence one extra bit.
  typedef logic [ADDR_W:0]   cnt_t;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDrain
  } rd_state_t;

endpackage

// File: rtl/m10k_stream_reader_if.sv
// Control, M10K read port and output stream of the reader, bundled as one interface.
interface m10k_stream_reader_if;
  import m10k_stream_reader_pkg::*;

  logic  start;
  addr_t base_addr;
  cnt_t  length;
  logic  busy;
  logic  done;

  logic  mem_read;
  logic  mem_write;
  addr_t mem_address;
  word_t mem_readdata;

  logic  out_valid;
  logic  out_ready;
  word_t out_data;
  logic  out_last;

  modport master (
    input  start, base_addr, length, mem_readdata, out_ready,
    output busy, done, mem_read, mem_write, mem_address, out_valid, out_data, out_last
  );

  modport slave (
    output start, base_addr, length, mem_readdata, out_ready,
    input  busy, done, mem_read, mem_write, mem_address, out_valid, out_data, out_last
  );

endinterface

// File: rtl/m10k_stream_reader_fifo.sv
// Fall-through FIFO: an incoming word is visible on rdata_o in the same cycle when empty.
module m10k_stream_reader_fifo #(
  parameter int unsigned Width = 33,
  parameter int unsigned Depth = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         push_i,
  input  logic [Width-1:0]             wdata_i,
  input  logic                         pop_i,
  output logic [Width-1:0]             rdata_o,
  output logic [$clog2(Depth):0]       count_o,
  output logic                         full_o,
  output logic                         empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [CntW-1:0]  cnt_q;
  logic             store, deq;

  always_comb begin
    empty_o = (cnt_q == '0);
    full_o  = (cnt_q == CntW'(Depth));
    count_o = cnt_q;
    rdata_o = empty_o ? wdata_i : mem_q[rptr_q];
    // A word pushed and popped in the same cycle while empty bypasses storage.
    store   = push_i && !(empty_o && pop_i);
    deq     = pop_i && !empty_o;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (store) begin
        mem_q[wptr_q] <= wdata_i;
        wptr_q        <= wptr_q + PtrW'(1);
      end
      if (deq) begin
        rptr_q <= rptr_q + PtrW'(1);
      end
      cnt_q <= cnt_q + CntW'(store) - CntW'(deq);
    end
  end

endmodule

// File: rtl/m10k_stream_reader.sv
// Issues sequential M10K reads under a credit limit and streams the words out with backpressure.
module m10k_stream_reader
  import m10k_stream_reader_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  m10k_stream_reader_if.master bus
);

  localparam int unsigned CntW = $clog2(BUF_D) + 1;

  rd_state_t         state_q, state_d;
  addr_t             base_q, base_d;
  cnt_t              len_q, len_d;
  cnt_t              issued_q, issued_d;
  logic              done_q, done_d;
  logic              inflight_q;
  logic              last_tag_q;

  logic              mem_read;
  logic              is_last_read;
  logic              out_valid;
  logic              hs;
  logic [DATA_W:0]   fifo_rdata;
  logic [CntW-1:0]   fifo_count;
  logic              fifo_full;
  logic              fifo_empty;

  m10k_stream_reader_fifo #(
    .Width (DATA_W + 1),
    .Depth (BUF_D)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (inflight_q),
    .wdata_i ({last_tag_q, bus.mem_readdata}),
    .pop_i   (hs),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    // Credits: stored words plus the read in flight must never exceed the buffer.
    mem_read     = (state_q == StIssue) && !fifo_full &&
                   ((32'(fifo_count) + 32'(inflight_q)) < 32'(BUF_D));
    is_last_read = (issued_q == (len_q - cnt_t'(1)));
    out_valid    = !fifo_empty || inflight_q;
    hs           = out_valid && bus.out_ready;

    state_d  = state_q;
    base_d   = base_q;
    len_d    = len_q;
    issued_d = issued_q;
    done_d   = 1'b0;

    case (state_q)
      StIdle: begin
        if (bus.start) begin
          if (bus.length == '0) begin
            done_d = 1'b1;
          end else begin
            base_d   = bus.base_addr;
            len_d    = bus.length;
            issued_d = '0;
            state_d  = StIssue;
          end
        end
      end
      StIssue: begin
        if (mem_read) begin
          issued_d = issued_q + cnt_t'(1);
          if (issued_d == len_q) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (hs && fifo_rdata[DATA_W]) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.busy        = (state_q != StIdle);
    bus.done        = done_q;
    bus.mem_read    = mem_read;
    bus.mem_write   = 1'b0;
    bus.mem_address = base_q + issued_q[ADDR_W-1:0];
    bus.out_valid   = out_valid;
    bus.out_data    = fifo_rdata[DATA_W-1:0];
    bus.out_last    = out_valid && fifo_rdata[DATA_W];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      base_q     <= '0;
      len_q      <= '0;
      issued_q   <= '0;
      done_q     <= 1'b0;
      inflight_q <= 1'b0;
      last_tag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      done_q     <= done_d;
      inflight_q <= mem_read;
      last_tag_q <= mem_read && is_last_read;
    end
  end

endmodule

// File: tb/tb_m10k_stream_reader.sv
// Directed bench for m10k_stream_reader with a registered-read M10K model.
module tb_m10k_stream_reader;
  import m10k_stream_reader_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  m10k_stream_reader_if bus_if ();

  m10k_stream_reader dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus_if)
  );

  // Memory content: each word is 0xD0000000 | address, returned one cycle after the strobe.
  always @(posedge clk) begin
    if (bus_if.mem_read) bus_if.mem_readdata <= 32'hD000_0000 | 32'(bus_if.mem_address);
  end

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  word_t got_data [$];
  logic  got_last [$];
  int    hs_cyc   [$];
  addr_t rd_addr  [$];
  int    rd_cyc   [$];
  int    done_cyc [$];
  int    valid_seen;

  always @(negedge clk) begin
    if (bus_if.mem_read) begin
      rd_addr.push_back(bus_if.mem_address);
      rd_cyc.push_back(cyc);
    end
    if (bus_if.out_valid && bus_if.out_ready) begin
      got_data.push_back(bus_if.out_data);
      got_last.push_back(bus_if.out_last);
      hs_cyc.push_back(cyc);
    end
    if (bus_if.out_valid) valid_seen = valid_seen + 1;
    if (bus_if.done) done_cyc.push_back(cyc);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks = n_checks + 1;
    if (got === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    got_data.delete();
    got_last.delete();
    hs_cyc.delete();
    rd_addr.delete();
    rd_cyc.delete();
    done_cyc.delete();
    valid_seen = 0;
  endtask

  task automatic start_xfer(input addr_t b, input cnt_t l);
    bus_if.start     = 1'b1;
    bus_if.base_addr = b;
    bus_if.length    = l;
    tick(1);
    bus_if.start     = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k = 0;
    while (done_cyc.size() == 0 && k < budget) begin
      tick(1);
      k++;
    end
    check_eq({tag, "_done_seen"}, 64'(done_cyc.size()), 64'd1);
  endtask

  task automatic check_stream(input string tag, input addr_t b, input int n);
    check_eq({tag, "_count"}, 64'(got_data.size()), 64'(n));
    for (int i = 0; i < n; i++) begin
      addr_t a;
      a = addr_t'(32'(b) + i);
      if (i < got_data.size()) begin
        check_eq($sformatf("%s_data%0d", tag, i), 64'(got_data[i]), 64'(32'hD000_0000 | 32'(a)));
        check_eq($sformatf("%s_last%0d", tag, i), 64'(got_last[i]), 64'(i == n - 1));
      end
      if (i < rd_addr.size()) begin
        check_eq($sformatf("%s_addr%0d", tag, i), 64'(rd_addr[i]), 64'(a));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DATA_W-1:0] hold;
    int k;
    valid_seen       = 0;
    rst              = 1'b1;
    bus_if.start     = 1'b0;
    bus_if.base_addr = '0;
    bus_if.length    = '0;
    bus_if.out_ready = 1'b0;
    tick(3);

    check_eq("rst_busy",     64'(bus_if.busy),        64'd0);
    check_eq("rst_done",     64'(bus_if.done),        64'd0);
    check_eq("rst_mem_read", 64'(bus_if.mem_read),    64'd0);
    check_eq("rst_mem_addr", 64'(bus_if.mem_address), 64'd0);
    check_eq("rst_valid",    64'(bus_if.out_valid),   64'd0);
    check_eq("rst_last",     64'(bus_if.out_last),    64'd0);
    rst = 1'b0;
    tick(2);

    // Basic transfer at full throughput.
    clear_mon();
    bus_if.out_ready = 1'b1;
    start_xfer(8'h10, 9'd4);
    check_eq("t1_read_t1", 64'(bus_if.mem_read),    64'd1);
    check_eq("t1_addr_t1", 64'(bus_if.mem_address), 64'h10);
    check_eq("t1_busy",    64'(bus_if.busy),        64'd1);
    wait_done("t1", 50);
    tick(3);
    check_stream("t1", 8'h10, 4);
    check_eq("t1_read_span", 64'((rd_cyc.size() == 4) ? rd_cyc[3] - rd_cyc[0] : -1), 64'd3);
    check_eq("t1_first_lat", 64'((hs_cyc.size() > 0 && rd_cyc.size() > 0) ?
                                 hs_cyc[0] - rd_cyc[0] : -1), 64'd1);
    check_eq("t1_done_lat", 64'((hs_cyc.size() == 4 && done_cyc.size() > 0) ?
                                done_cyc[0] - hs_cyc[3] : -1), 64'd1);
    check_eq("t1_done_cnt", 64'(done_cyc.size()), 64'd1);

    // Address wrap past 0xFF.
    clear_mon();
    start_xfer(8'hFE, 9'd4);
    wait_done("t2", 50);
    tick(2);
    check_stream("t2", 8'hFE, 4);

    // Backpressure: issuing stops at the credit limit and output holds steady.
    clear_mon();
    bus_if.out_ready = 1'b0;
    start_xfer(8'h30, 9'd8);
    tick(1);
    check_eq("t3_valid_t2", 64'(bus_if.out_valid), 64'd1);
    hold = bus_if.out_data;
    check_eq("t3_first_data", 64'(hold), 64'hD000_0030);
    tick(8);
    check_eq("t3_data_stable", 64'(bus_if.out_data), 64'(hold));
    check_eq("t3_reads_held", 64'(rd_addr.size()), 64'(BUF_D));
    bus_if.out_ready = 1'b1;
    wait_done("t3", 80);
    tick(2);
    check_stream("t3", 8'h30, 8);

    // Zero-length start.
    clear_mon();
    start_xfer(8'h55, 9'd0);
    check_eq("t4_done_t1", 64'(bus_if.done), 64'd1);
    check_eq("t4_busy",    64'(bus_if.busy), 64'd0);
    tick(5);
    check_eq("t4_no_reads", 64'(rd_addr.size()),  64'd0);
    check_eq("t4_no_valid", 64'(valid_seen),      64'd0);
    check_eq("t4_one_done", 64'(done_cyc.size()), 64'd1);

    // Reset mid-transfer, then a clean restart.
    clear_mon();
    start_xfer(8'h40, 9'd16);
    k = 0;
    while (got_data.size() < 5 && k < 50) begin
      tick(1);
      k++;
    end
    check_eq("t5_five_words", 64'(got_data.size() >= 5), 64'd1);
    rst = 1'b1;
    tick(1);
    check_eq("t5_busy",     64'(bus_if.busy),        64'd0);
    check_eq("t5_done",     64'(bus_if.done),        64'd0);
    check_eq("t5_mem_read", 64'(bus_if.mem_read),    64'd0);
    check_eq("t5_mem_addr", 64'(bus_if.mem_address), 64'd0);
    check_eq("t5_valid",    64'(bus_if.out_valid),   64'd0);
    check_eq("t5_last",     64'(bus_if.out_last),    64'd0);
    rst = 1'b0;
    tick(4);
    check_eq("t5_no_done", 64'(done_cyc.size()), 64'd0);
    clear_mon();
    start_xfer(8'h20, 9'd2);
    wait_done("t5b", 50);
    tick(2);
    check_stream("t5b", 8'h20, 2);

    // A second start while busy is ignored.
    clear_mon();
    start_xfer(8'h80, 9'd6);
    bus_if.base_addr = 8'h00;
    bus_if.length    = 9'd3;
    bus_if.start     = 1'b1;
    tick(1);
    bus_if.start     = 1'b0;
    wait_done("t6", 60);
    tick(5);
    check_stream("t6", 8'h80, 6);
    check_eq("t6_one_done", 64'(done_cyc.size()), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
